// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select add/sub: BLK-bit select blocks, a register every BLK_PER_STAGE blocks, L-cycle latency.
// Valid/ready stream; a stalled stage holds its data, ready ripples back combinationally through all stages.
module csa_pipe_adder #(
   parameter int WIDTH         = 22,
   parameter int BLK           = 4,
   parameter int BLK_PER_STAGE = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add_term1,
   input  logic [WIDTH-1:0] i_add_term2,
   input  logic             i_sub,
   input  logic             i_cin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int NBLK = (WIDTH + BLK - 1) / BLK;
   localparam int L    = (NBLK + BLK_PER_STAGE - 1) / BLK_PER_STAGE;

   logic [L-1:0]            r_v;
   logic [L-1:0]            r_c;
   logic [L-1:0][WIDTH-1:0] r_sum;
   logic [L-1:0][WIDTH-1:0] r_a;
   logic [L-1:0][WIDTH-1:0] r_b;
   logic                    r_cmsb;

   logic [L-1:0]            w_rdy;
   logic [L-1:0]            w_up_v;
   logic [L-1:0]            w_in_c;
   logic [L-1:0]            w_out_c;
   logic [L-1:0][WIDTH-1:0] w_in_a;
   logic [L-1:0][WIDTH-1:0] w_in_b;
   logic [L-1:0][WIDTH-1:0] w_in_sum;
   logic [L-1:0][WIDTH-1:0] w_out_sum;
   logic                    w_cmsb;

   always_comb begin : stage_logic
      logic             rdy;
      logic [WIDTH-1:0] t0;
      logic [WIDTH-1:0] t1;
      logic             c;
      logic             c0;
      logic             c1;
      int               idx;

      rdy       = i_ready;
      t0        = '0;
      t1        = '0;
      c         = 1'b0;
      c0        = 1'b0;
      c1        = 1'b0;
      idx       = 0;
      w_rdy     = '0;
      w_up_v    = '0;
      w_in_c    = '0;
      w_out_c   = '0;
      w_in_a    = '0;
      w_in_b    = '0;
      w_in_sum  = '0;
      w_out_sum = '0;

      for (int s = L - 1; s >= 0; s--) begin
         rdy      = ~r_v[s] | rdy;
         w_rdy[s] = rdy;
      end

      // Subtract folds into the first stage: invert B and the borrow-in.
      w_up_v[0]   = i_valid;
      w_in_a[0]   = i_add_term1;
      w_in_b[0]   = i_sub ? ~i_add_term2 : i_add_term2;
      w_in_c[0]   = i_cin ^ i_sub;
      w_in_sum[0] = '0;
      for (int s = 1; s < L; s++) begin
         w_up_v[s]   = r_v[s-1];
         w_in_a[s]   = r_a[s-1];
         w_in_b[s]   = r_b[s-1];
         w_in_c[s]   = r_c[s-1];
         w_in_sum[s] = r_sum[s-1];
      end

      for (int s = 0; s < L; s++) begin
         c            = w_in_c[s];
         w_out_sum[s] = w_in_sum[s];
         for (int k = 0; k < NBLK; k++) begin
            if (k / BLK_PER_STAGE == s) begin
               c0 = 1'b0;
               c1 = 1'b1;
               for (int j = 0; j < BLK; j++) begin
                  idx = k * BLK + j;
                  if (idx < WIDTH) begin
                     t0[idx] = w_in_a[s][idx] ^ w_in_b[s][idx] ^ c0;
                     t1[idx] = w_in_a[s][idx] ^ w_in_b[s][idx] ^ c1;
                     c0 = (w_in_a[s][idx] & w_in_b[s][idx]) | (c0 & (w_in_a[s][idx] ^ w_in_b[s][idx]));
                     c1 = (w_in_a[s][idx] & w_in_b[s][idx]) | (c1 & (w_in_a[s][idx] ^ w_in_b[s][idx]));
                  end
               end
               for (int j = 0; j < BLK; j++) begin
                  idx = k * BLK + j;
                  if (idx < WIDTH) begin
                     w_out_sum[s][idx] = c ? t1[idx] : t0[idx];
                  end
               end
               c = c ? c1 : c0;
            end
         end
         w_out_c[s] = c;
      end

      // Carry into the MSB falls out of the MSB's own sum bit.
      w_cmsb = w_in_a[L-1][WIDTH-1] ^ w_in_b[L-1][WIDTH-1] ^ w_out_sum[L-1][WIDTH-1];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_v    <= '0;
         r_c    <= '0;
         r_sum  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_cmsb <= 1'b0;
      end else begin
         for (int s = 0; s < L; s++) begin
            if (w_rdy[s]) begin
               r_v[s] <= w_up_v[s];
               if (w_up_v[s]) begin
                  r_sum[s] <= w_out_sum[s];
                  r_a[s]   <= w_in_a[s];
                  r_b[s]   <= w_in_b[s];
                  r_c[s]   <= w_out_c[s];
               end
            end
         end
         if (w_rdy[L-1] && w_up_v[L-1]) begin
            r_cmsb <= w_cmsb;
         end
      end
   end

   assign o_ready = w_rdy[0];
   assign o_valid = r_v[L-1];
   assign o_sum   = r_sum[L-1];
   assign o_cout  = r_c[L-1];
   assign o_ovf   = r_cmsb ^ r_c[L-1];

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: three parameterisations, directed vectors, random streams with back-pressure.
module tb_csa_pipe_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]  ival, irdy, isub, icin;
   logic [21:0] a0, b0;
   logic [15:0] a1, b1;
   logic [6:0]  a2, b2;
   wire  [2:0]  ordy, ovld, ocout, oovf;
   wire  [21:0] s0;
   wire  [15:0] s1;
   wire  [6:0]  s2;

   int checks   = 0;
   int failures = 0;

   csa_pipe_adder u0 (
      .i_clk(clk), .i_rst(rst), .i_valid(ival[0]), .o_ready(ordy[0]),
      .i_add_term1(a0), .i_add_term2(b0), .i_sub(isub[0]), .i_cin(icin[0]),
      .o_valid(ovld[0]), .i_ready(irdy[0]), .o_sum(s0), .o_cout(ocout[0]), .o_ovf(oovf[0]));

   csa_pipe_adder #(.WIDTH(16), .BLK(4), .BLK_PER_STAGE(1)) u1 (
      .i_clk(clk), .i_rst(rst), .i_valid(ival[1]), .o_ready(ordy[1]),
      .i_add_term1(a1), .i_add_term2(b1), .i_sub(isub[1]), .i_cin(icin[1]),
      .o_valid(ovld[1]), .i_ready(irdy[1]), .o_sum(s1), .o_cout(ocout[1]), .o_ovf(oovf[1]));

   csa_pipe_adder #(.WIDTH(7), .BLK(3), .BLK_PER_STAGE(8)) u2 (
      .i_clk(clk), .i_rst(rst), .i_valid(ival[2]), .o_ready(ordy[2]),
      .i_add_term1(a2), .i_add_term2(b2), .i_sub(isub[2]), .i_cin(icin[2]),
      .o_valid(ovld[2]), .i_ready(irdy[2]), .o_sum(s2), .o_cout(ocout[2]), .o_ovf(oovf[2]));

   typedef struct {
      string       name;
      logic [21:0] a;
      logic [21:0] b;
      bit          sub;
      bit          cin;
      logic [21:0] sum;
      bit          cout;
      bit          ovf;
   } vec_t;

   function automatic int wd(int i);
      return (i == 0) ? 22 : (i == 1) ? 16 : 7;
   endfunction

   function automatic int lat(int i);
      return (i == 0) ? 3 : (i == 1) ? 4 : 1;
   endfunction

   // Packed result word: sum in [21:0], cout bit 40, ovf bit 41, valid bit 42.
   function automatic logic [63:0] pack(logic [21:0] sum, bit cout, bit ovf, bit vld);
      logic [63:0] r;
      r       = '0;
      r[21:0] = sum;
      r[40]   = cout;
      r[41]   = ovf;
      r[42]   = vld;
      return r;
   endfunction

   function automatic logic [63:0] get_out(int i);
      case (i)
         0:       return pack(s0, ocout[0], oovf[0], ovld[0]);
         1:       return pack({6'b0, s1}, ocout[1], oovf[1], ovld[1]);
         default: return pack({15'b0, s2}, ocout[2], oovf[2], ovld[2]);
      endcase
   endfunction

   // Reference: plain integer arithmetic, signed overflow from operand/result signs.
   function automatic logic [63:0] model(int w, longint a, longint b, bit sub, bit cin);
      longint m, am, bx, full, s;
      bit     sa, sb, ss;
      m    = (longint'(1) << w) - 1;
      am   = a & m;
      bx   = sub ? (~b & m) : (b & m);
      full = am + bx + longint'(sub ? !cin : cin);
      s    = full & m;
      sa   = am[w-1];
      sb   = bx[w-1];
      ss   = s[w-1];
      return pack(s[21:0], full[w], (sa == sb) && (ss != sa), 1'b1);
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic drive(int i, bit v, longint a, longint b, bit sub, bit cin);
      ival[i] = v;
      isub[i] = sub;
      icin[i] = cin;
      case (i)
         0:       begin a0 = a[21:0]; b0 = b[21:0]; end
         1:       begin a1 = a[15:0]; b1 = b[15:0]; end
         default: begin a2 = a[6:0];  b2 = b[6:0];  end
      endcase
   endtask

   // One isolated transaction: checks latency (o_valid low until edge n+L-1) and the result, then drains.
   task automatic apply_vec(string name, int i, longint a, longint b, bit sub, bit cin, logic [63:0] exp);
      @(negedge clk);
      irdy[i] = 1'b1;
      drive(i, 1'b1, a, b, sub, cin);
      #1 check({name, "_rdy"}, 64'(ordy[i]), 64'd1);
      @(posedge clk);
      #1 drive(i, 1'b0, 0, 0, 1'b0, 1'b0);
      for (int k = 0; k < lat(i); k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (k < lat(i) - 1) check({name, "_lat"}, 64'(ovld[i]), 64'd0);
         else                check(name, get_out(i), exp);
      end
      @(posedge clk);
      #1;
   endtask

   // Random stream with random back-pressure; scoreboard queue plus occupancy count.
   task automatic run_stream(string name, int i, int n, int rdy_pct);
      logic [63:0] q[$];
      logic [63:0] held, e;
      longint      ca, cb, m;
      bit          cs, cc, pending, hold_chk, xin, xout;
      int          sent, got, cyc, occ;
      m = (longint'(1) << wd(i)) - 1;
      sent = 0; got = 0; cyc = 0; occ = 0;
      pending = 1'b0; hold_chk = 1'b0; held = '0;
      ca = 0; cb = 0; cs = 1'b0; cc = 1'b0;
      while (got < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (!pending && sent < n) begin
            ca = longint'($urandom) & m;
            cb = longint'($urandom) & m;
            cs = 1'($urandom_range(1));
            cc = 1'($urandom_range(1));
            pending = 1'b1;
         end
         drive(i, pending, ca, cb, cs, cc);
         irdy[i] = ($urandom_range(99) < rdy_pct);
         #1;
         check({name, "_ordy"}, 64'(ordy[i]), 64'(!(occ == lat(i) && !irdy[i])));
         if (hold_chk) check({name, "_hold"}, get_out(i), held);
         xin  = ival[i] & ordy[i];
         xout = ovld[i] & irdy[i];
         if (xout) begin
            if (q.size() == 0) begin
               check({name, "_dup"}, 64'(q.size()), 64'd1);
            end else begin
               e = q.pop_front();
               check({name, "_data"}, get_out(i), e);
            end
            got++;
         end
         hold_chk = ovld[i] & !irdy[i];
         held     = get_out(i);
         if (xin) begin
            q.push_back(model(wd(i), ca, cb, cs, cc));
            sent++;
            pending = 1'b0;
         end
         occ = occ + int'(xin) - int'(xout);
      end
      check({name, "_count"}, 64'(got), 64'(n));
      if (rdy_pct >= 100) check({name, "_thruput"}, 64'(cyc), 64'(n + lat(i)));
      @(negedge clk);
      drive(i, 1'b0, 0, 0, 1'b0, 1'b0);
      irdy[i] = 1'b1;
      repeat (lat(i) + 2) @(negedge clk);
      check({name, "_no_extra"}, 64'(ovld[i]), 64'd0);
   endtask

   vec_t vt[7];

   initial begin
      vt[0] = '{"add_wrap",   22'h3FFFFF, 22'h000001, 1'b0, 1'b0, 22'h000000, 1'b1, 1'b0};
      vt[1] = '{"add_ovf",    22'h1FFFFF, 22'h000001, 1'b0, 1'b0, 22'h200000, 1'b0, 1'b1};
      vt[2] = '{"add_cin",    22'h000000, 22'h000000, 1'b0, 1'b1, 22'h000001, 1'b0, 1'b0};
      vt[3] = '{"sub_borrow", 22'h000005, 22'h000007, 1'b1, 1'b0, 22'h3FFFFE, 1'b0, 1'b0};
      vt[4] = '{"sub_ovf",    22'h200000, 22'h000001, 1'b1, 1'b0, 22'h1FFFFF, 1'b1, 1'b1};
      vt[5] = '{"sub_bin",    22'h000007, 22'h000003, 1'b1, 1'b1, 22'h000003, 1'b1, 1'b0};
      vt[6] = '{"add_chain",  22'h155555, 22'h2AAAAA, 1'b0, 1'b1, 22'h000000, 1'b1, 1'b0};

      rst  = 1'b1;
      ival = '0; irdy = '1; isub = '0; icin = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
      #2;
      for (int i = 0; i < 3; i++) begin
         check("reset_out", get_out(i), 64'd0);
         check("reset_rdy", 64'(ordy[i]), 64'd1);
      end
      #20;
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 7; k++)
         apply_vec(vt[k].name, 0, longint'(vt[k].a), longint'(vt[k].b), vt[k].sub, vt[k].cin,
                   pack(vt[k].sum, vt[k].cout, vt[k].ovf, 1'b1));

      apply_vec("w16_wrap", 1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, pack(22'h0, 1'b1, 1'b0, 1'b1));
      apply_vec("w16_sub",  1, 64'h8000, 64'h0001, 1'b1, 1'b0, pack(22'h7FFF, 1'b1, 1'b1, 1'b1));
      apply_vec("w7_wrap",  2, 64'h7F,   64'h01,   1'b0, 1'b0, pack(22'h0, 1'b1, 1'b0, 1'b1));
      apply_vec("w7_ovf",   2, 64'h3F,   64'h01,   1'b0, 1'b0, pack(22'h40, 1'b0, 1'b1, 1'b1));

      run_stream("s22", 0, 12, 50);
      run_stream("s22f", 0, 10, 100);
      run_stream("s16", 1, 30, 60);
      run_stream("s7", 2, 30, 60);

      // Reset with two results in flight under back-pressure.
      @(negedge clk);
      irdy[0] = 1'b0;
      drive(0, 1'b1, 64'h1FFFFF, 64'h1, 1'b0, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b1, 64'h3FFFFF, 64'h1, 1'b0, 1'b0);
      @(posedge clk);
      #1 drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
      @(posedge clk);
      #1 check("rst_pre", get_out(0), pack(22'h200000, 1'b0, 1'b1, 1'b1));
      #2 rst = 1'b1;
      #1 check("rst_clear", get_out(0), 64'd0);
      check("rst_rdy", 64'(ordy[0]), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      irdy[0] = 1'b1;
      apply_vec("rst_after", 0, 64'd3, 64'd4, 1'b0, 1'b0, pack(22'd7, 1'b0, 1'b0, 1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface. Operands are split into BLK-bit carry-select blocks; the last block takes the WIDTH mod BLK remainder bits. A register stage follows every BLK_PER_STAGE blocks, so wide adds close timing at a chosen depth. The block sits in the arithmetic datapath as the clocked, back-pressure-aware successor to the fixed-width combinational carry-select adders.

## Interface
- WIDTH, 22: operand/result width, ≥2.
- BLK, 4: carry-select block size, 1..WIDTH.
- BLK_PER_STAGE, 2: blocks evaluated per pipeline stage, ≥1.
- Derived, not overridable:
  - NBLK = ceil(WIDTH/BLK).
  - L = ceil(NBLK/BLK_PER_STAGE), the number of register stages. Defaults give NBLK=6 and L=3.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept input this cycle.
- i_add_term1  in  WIDTH  operand A.
- i_add_term2  in  WIDTH  operand B.
- i_sub  in  1  0 = add, 1 = subtract.
- i_cin  in  1  carry-in when adding; borrow-in when subtracting.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_sum  out  WIDTH  result.
- o_cout  out  1  carry-out when adding; NOT-borrow when subtracting.
- o_ovf  out  1  two's-complement signed overflow.

## Operation
- Add: {o_cout,o_sum} = A + B + i_cin.
- Subtract: {o_cout,o_sum} = A + ~B + ~i_cin, i.e. A − B − i_cin. o_cout=0 means a borrow occurred.
- o_ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. It applies to both modes.
- Each block computes two sums in parallel, one with cin=0 and one with cin=1. The incoming block carry selects between them.
- Block 0 uses the effective carry-in directly.
- The final block is WIDTH−BLK*(NBLK−1) bits wide. When WIDTH is divisible by BLK, it is a full BLK block; no zero-width block exists.
- Stage s (1..L) evaluates blocks (s−1)*BLK_PER_STAGE .. min(s*BLK_PER_STAGE, NBLK)−1. Stage 1 works combinationally from the inputs; stage s>1 works from the stage s−1 registers.
- Each stage register holds:
  - valid bit
  - sum bits computed so far
  - unprocessed operand bits, with B already inverted for subtract
  - running carry
  - for the last stage only, the carry into the MSB
- Stage L registers drive o_sum, o_cout, o_ovf and o_valid directly. There is no combinational path from the inputs to the outputs.
- Handshake:
  - Ready chain: rdy_{L+1} = i_ready; rdy_s = !v_s | rdy_{s+1}; o_ready = rdy_1.
  - A stage loads when its rdy_s is high. It takes the upstream valid and data, or clears its valid when upstream is empty.
  - A stalled stage (v_s=1, rdy_{s+1}=0) holds its data unchanged.
  - Transfer in: i_valid & o_ready at a clock edge. Transfer out: o_valid & i_ready at a clock edge.
  - Input data are sampled only on a transfer-in. When o_ready=0, the inputs are don't-care.
- Reset (asynchronous, any time, including with results in flight):
  - All stage valids = 0, all data registers = 0.
  - Hence o_valid=0, o_sum=0, o_cout=0, o_ovf=0.
  - In-flight results are discarded.
  - o_ready=1 after reset, since the pipeline is empty.
- If BLK_PER_STAGE ≥ NBLK, then L=1 and the block is a single registered stage.

## Timing
- Latency: a transfer-in at edge n gives o_valid=1 with the result after edge n+L−1, provided there are no stalls. For the defaults, the result is visible after edge n+2.
- Throughput: one result per clock while i_ready=1.
- Full pipeline with i_ready=0: o_ready drops in the same cycle, combinationally via the ready chain. Nothing is lost or duplicated.
- Simultaneous transfer-in and transfer-out with a full pipeline: both complete, and the pipeline stays full.
- Back-pressure holds o_sum, o_cout and o_ovf stable while o_valid=1 and i_ready=0.
- The ready chain is combinational through L stages. Valids and data are fully registered.

## Test plan
- Add, defaults, A=0x3FFFFF, B=0x000001, cin=0 → after 3 edges: o_sum=0x000000, o_cout=1, o_ovf=0.
- Add, A=0x1FFFFF, B=0x000001, cin=0 → o_sum=0x200000, o_cout=0, o_ovf=1. Separately, cin=1 with A=B=0x000000 → o_sum=0x000001.
- Subtract:
  - A=0x000005, B=0x000007, cin=0 → o_sum=0x3FFFFE, o_cout=0, o_ovf=0.
  - A=0x200000, B=0x000001 → o_sum=0x1FFFFF, o_cout=1, o_ovf=1.
- Streaming with stalls: 10 back-to-back random transactions with i_ready toggling pseudo-randomly → outputs match a reference model in order. There are no drops or duplicates, o_ready=0 only when all 3 stages are full and i_ready=0, and the outputs are stable during stalls.
- Reset mid-flight: 2 transactions in flight, assert i_rst between edges → o_valid=0, o_sum=0, o_cout=0, o_ovf=0 immediately. After release, o_ready=1 and a new add (3+4) returns 7 after 3 edges.
- Parameter sweeps, random add/sub checked against the model:
  - WIDTH=16, BLK=4, BLK_PER_STAGE=1: L=4, no remainder block.
  - WIDTH=7, BLK=3, BLK_PER_STAGE=8: L=1, 1-bit last block.
